top_decode: RTL and testbench

//  Decode stage of the multi-cycle RV32I core, directly downstream of top_fetch.

---
 rtl/top_decode.sv | 248 ++++++++++++++++++++++++
 tb/tb_top_decode.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/top_decode.sv
// Decode stage of the multi-cycle RV32I core: registers decoded fields of inst on phase_decode.
// Optional RV32M decode is enabled by defining RV32M_EN; otherwise mul_div is tied to 0.
module top_decode #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            phase_decode,
    input  logic            stall_fetch,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] curr_pc_fd,
    input  logic [XLEN-1:0] next_pc_fd,
    output logic [XLEN-1:0] curr_pc_de,
    output logic [XLEN-1:0] next_pc_de,
    output logic [4:0]      rs1_sel,
    output logic [4:0]      rs2_sel,
    output logic [4:0]      rd_sel,
    output logic [XLEN-1:0] imm,
    output logic [3:0]      alu_ctl,
    output logic            use_imm,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic [1:0]      jump_type,
    output logic            mul_div,
    output logic            illegal_inst,
    output logic            valid_de
);

    typedef enum logic [6:0] {
        OPC_LUI      = 7'b0110111,
        OPC_AUIPC    = 7'b0010111,
        OPC_JAL      = 7'b1101111,
        OPC_JALR     = 7'b1100111,
        OPC_BRANCH   = 7'b1100011,
        OPC_LOAD     = 7'b0000011,
        OPC_STORE    = 7'b0100011,
        OPC_OP_IMM   = 7'b0010011,
        OPC_OP       = 7'b0110011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef enum logic [1:0] {
        JT_NONE   = 2'b00,
        JT_JAL    = 2'b01,
        JT_JALR   = 2'b10,
        JT_BRANCH = 2'b11
    } jump_e;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    logic [4:0]  rd_d;
    logic [31:0] imm32_d;
    logic [3:0]  alu_ctl_d;
    logic        use_imm_d;
    logic        reg_write_d;
    logic        mem_read_d;
    logic        mem_write_d;
    jump_e       jump_d;
    logic        illegal_d;
`ifdef RV32M_EN
    logic        mul_div_d;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        rd_d        = inst[11:7];
        imm32_d     = '0;
        alu_ctl_d   = {1'b0, funct3};
        use_imm_d   = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        jump_d      = JT_NONE;
        illegal_d   = 1'b0;
`ifdef RV32M_EN
        mul_div_d   = 1'b0;
`endif

        if (inst[1:0] != 2'b11) begin
            illegal_d = 1'b1;
        end else begin
            case (opcode)
                OPC_LUI, OPC_AUIPC: begin
                    imm32_d     = {inst[31:12], 12'b0};
                    use_imm_d   = 1'b1;
                    reg_write_d = 1'b1;
                end
                OPC_JAL: begin
                    imm32_d     = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                    use_imm_d   = 1'b1;
                    reg_write_d = 1'b1;
                    jump_d      = JT_JAL;
                end
                OPC_JALR: begin
                    imm32_d     = {{20{inst[31]}}, inst[31:20]};
                    use_imm_d   = 1'b1;
                    reg_write_d = 1'b1;
                    jump_d      = JT_JALR;
                end
                OPC_BRANCH: begin
                    imm32_d = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                    rd_d    = 5'd0;
                    jump_d  = JT_BRANCH;
                end
                OPC_LOAD: begin
                    imm32_d     = {{20{inst[31]}}, inst[31:20]};
                    use_imm_d   = 1'b1;
                    reg_write_d = 1'b1;
                    mem_read_d  = 1'b1;
                end
                OPC_STORE: begin
                    imm32_d     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                    rd_d        = 5'd0;
                    use_imm_d   = 1'b1;
                    mem_write_d = 1'b1;
                end
                OPC_OP_IMM: begin
                    imm32_d     = {{20{inst[31]}}, inst[31:20]};
                    use_imm_d   = 1'b1;
                    reg_write_d = 1'b1;
                    if (funct3 == 3'b001 || funct3 == 3'b101) alu_ctl_d[3] = inst[30];
                end
                OPC_OP: begin
                    reg_write_d  = 1'b1;
                    alu_ctl_d[3] = inst[30];
                    if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                        illegal_d = 1'b0;
`ifdef RV32M_EN
                    end else if (funct7 == 7'b0000001) begin
                        mul_div_d = 1'b1;
`endif
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                OPC_MISC_MEM, OPC_SYSTEM: begin
                    alu_ctl_d = 4'd0;
                end
                default: illegal_d = 1'b1;
            endcase
        end

        // An illegal encoding must not trigger any architectural side effect downstream.
        if (illegal_d) begin
            imm32_d     = '0;
            alu_ctl_d   = 4'd0;
            use_imm_d   = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            jump_d      = JT_NONE;
`ifdef RV32M_EN
            mul_div_d   = 1'b0;
`endif
        end
        if (rd_d == 5'd0) reg_write_d = 1'b0;
    end

    logic [XLEN-1:0] curr_pc_q, next_pc_q, imm_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [3:0]      alu_ctl_q;
    logic            use_imm_q, reg_write_q, mem_read_q, mem_write_q;
    logic            illegal_q, valid_q;
    jump_e           jump_q;
`ifdef RV32M_EN
    logic            mul_div_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            curr_pc_q   <= RESET_VECTOR;
            next_pc_q   <= RESET_VECTOR + XLEN'(4);
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            alu_ctl_q   <= '0;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            jump_q      <= JT_NONE;
            illegal_q   <= 1'b0;
            valid_q     <= 1'b0;
`ifdef RV32M_EN
            mul_div_q   <= 1'b0;
`endif
        end else if (phase_decode) begin
            if (stall_fetch) begin
                // Bubble: kill side effects only; PCs and decoded fields keep their values.
                valid_q     <= 1'b0;
                reg_write_q <= 1'b0;
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                jump_q      <= JT_NONE;
            end else begin
                curr_pc_q   <= curr_pc_fd;
                next_pc_q   <= next_pc_fd;
                rs1_q       <= inst[19:15];
                rs2_q       <= inst[24:20];
                rd_q        <= rd_d;
                imm_q       <= XLEN'($signed(imm32_d));
                alu_ctl_q   <= alu_ctl_d;
                use_imm_q   <= use_imm_d;
                reg_write_q <= reg_write_d;
                mem_read_q  <= mem_read_d;
                mem_write_q <= mem_write_d;
                jump_q      <= jump_d;
                illegal_q   <= illegal_d;
                valid_q     <= 1'b1;
`ifdef RV32M_EN
                mul_div_q   <= mul_div_d;
`endif
            end
        end
    end

    assign curr_pc_de   = curr_pc_q;
    assign next_pc_de   = next_pc_q;
    assign rs1_sel      = rs1_q;
    assign rs2_sel      = rs2_q;
    assign rd_sel       = rd_q;
    assign imm          = imm_q;
    assign alu_ctl      = alu_ctl_q;
    assign use_imm      = use_imm_q;
    assign reg_write    = reg_write_q;
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign jump_type    = jump_q;
    assign illegal_inst = illegal_q;
    assign valid_de     = valid_q;
`ifdef RV32M_EN
    assign mul_div      = mul_div_q;
`else
    assign mul_div      = 1'b0;
`endif

endmodule

// File: tb/tb_top_decode.sv
// Directed-vector bench for top_decode; expected values are hand-decoded RV32I encodings.
// Define RV32M_EN for both bench and RTL to exercise the multiply/divide decode.
module tb_top_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        phase_decode = 1'b0;
    logic        stall_fetch = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] curr_pc_fd = '0;
    logic [31:0] next_pc_fd = '0;
    logic [31:0] curr_pc_de, next_pc_de, imm;
    logic [4:0]  rs1_sel, rs2_sel, rd_sel;
    logic [3:0]  alu_ctl;
    logic [1:0]  jump_type;
    logic        use_imm, reg_write, mem_read, mem_write, mul_div, illegal_inst, valid_de;

    int checks = 0;
    int errors = 0;

    top_decode dut (
        .clk          (clk),
        .rst          (rst),
        .phase_decode (phase_decode),
        .stall_fetch  (stall_fetch),
        .inst         (inst),
        .curr_pc_fd   (curr_pc_fd),
        .next_pc_fd   (next_pc_fd),
        .curr_pc_de   (curr_pc_de),
        .next_pc_de   (next_pc_de),
        .rs1_sel      (rs1_sel),
        .rs2_sel      (rs2_sel),
        .rd_sel       (rd_sel),
        .imm          (imm),
        .alu_ctl      (alu_ctl),
        .use_imm      (use_imm),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .jump_type    (jump_type),
        .mul_div      (mul_div),
        .illegal_inst (illegal_inst),
        .valid_de     (valid_de)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One decode strobe; outputs are sampled 1 time unit after the capturing edge.
    task automatic decode(input logic [31:0] i, input logic [31:0] pc, input logic stall);
        inst         = i;
        curr_pc_fd   = pc;
        next_pc_fd   = pc + 32'd4;
        stall_fetch  = stall;
        phase_decode = 1'b1;
        @(posedge clk);
        #1;
        phase_decode = 1'b0;
        stall_fetch  = 1'b0;
    endtask

    task automatic check_ctl(input string tag, input logic [3:0] alu, input logic ui,
                             input logic rw, input logic mr, input logic mw,
                             input logic [1:0] jt, input logic ill);
        check({tag, ".alu_ctl"}, 32'(alu_ctl), 32'(alu));
        check({tag, ".use_imm"}, 32'(use_imm), 32'(ui));
        check({tag, ".reg_write"}, 32'(reg_write), 32'(rw));
        check({tag, ".mem_read"}, 32'(mem_read), 32'(mr));
        check({tag, ".mem_write"}, 32'(mem_write), 32'(mw));
        check({tag, ".jump_type"}, 32'(jump_type), 32'(jt));
        check({tag, ".illegal"}, 32'(illegal_inst), 32'(ill));
        check({tag, ".valid"}, 32'(valid_de), 32'd1);
    endtask

    initial begin
        // Reset held for two clocks.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst.curr_pc", curr_pc_de, 32'h8000_0000);
        check("rst.next_pc", next_pc_de, 32'h8000_0004);
        check("rst.valid", 32'(valid_de), 32'd0);
        check("rst.imm", imm, 32'd0);
        check("rst.reg_write", 32'(reg_write), 32'd0);

        // addi x1, x0, -1
        decode(32'hFFF0_0093, 32'h8000_0000, 1'b0);
        check("addi.rd", 32'(rd_sel), 32'd1);
        check("addi.rs1", 32'(rs1_sel), 32'd0);
        check("addi.imm", imm, 32'hFFFF_FFFF);
        check("addi.curr_pc", curr_pc_de, 32'h8000_0000);
        check("addi.next_pc", next_pc_de, 32'h8000_0004);
        check_ctl("addi", 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

        // beq x1, x2, -4
        decode(32'hFE20_8EE3, 32'h8000_0004, 1'b0);
        check("beq.imm", imm, 32'hFFFF_FFFC);
        check("beq.rs1", 32'(rs1_sel), 32'd1);
        check("beq.rs2", 32'(rs2_sel), 32'd2);
        check("beq.rd", 32'(rd_sel), 32'd0);
        check("beq.curr_pc", curr_pc_de, 32'h8000_0004);
        check_ctl("beq", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);

        // Bubble: side effects cleared, PCs and fields held.
        decode(32'h0000_0013, 32'h8000_0100, 1'b1);
        check("bubble.valid", 32'(valid_de), 32'd0);
        check("bubble.jump", 32'(jump_type), 32'd0);
        check("bubble.curr_pc", curr_pc_de, 32'h8000_0004);
        check("bubble.imm", imm, 32'hFFFF_FFFC);
        check("bubble.rs2", 32'(rs2_sel), 32'd2);

        // nop (addi x0,x0,0): rd==0 suppresses reg_write.
        decode(32'h0000_0013, 32'h8000_0008, 1'b0);
        check_ctl("nop", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // All-zero word: inst[1:0] != 11.
        decode(32'h0000_0000, 32'h8000_000C, 1'b0);
        check_ctl("zero", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        check("zero.mul_div", 32'(mul_div), 32'd0);

        // mul x3, x1, x2
        decode(32'h0220_81B3, 32'h8000_0010, 1'b0);
`ifdef RV32M_EN
        check("mul.mul_div", 32'(mul_div), 32'd1);
        check_ctl("mul", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
`else
        check("mul.mul_div", 32'(mul_div), 32'd0);
        check_ctl("mul", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
`endif

        // lui x10, 0x12345
        decode(32'h1234_5537, 32'h8000_0014, 1'b0);
        check("lui.imm", imm, 32'h1234_5000);
        check("lui.rd", 32'(rd_sel), 32'd10);
        check_ctl("lui", 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

        // sw x2, -8(x1)
        decode(32'hFE20_AC23, 32'h8000_0018, 1'b0);
        check("sw.imm", imm, 32'hFFFF_FFF8);
        check("sw.rd", 32'(rd_sel), 32'd0);
        check_ctl("sw", 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);

        // lw x5, 4(x6)
        decode(32'h0043_2283, 32'h8000_001C, 1'b0);
        check("lw.imm", imm, 32'h0000_0004);
        check("lw.rs1", 32'(rs1_sel), 32'd6);
        check_ctl("lw", 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);

        // jal x1, +8
        decode(32'h0080_00EF, 32'h8000_0020, 1'b0);
        check("jal.imm", imm, 32'h0000_0008);
        check("jal.jump", 32'(jump_type), 32'd1);
        check("jal.reg_write", 32'(reg_write), 32'd1);

        // jalr x0, 0(x1): rd==0 so no write-back.
        decode(32'h0000_8067, 32'h8000_0024, 1'b0);
        check("jalr.jump", 32'(jump_type), 32'd2);
        check("jalr.reg_write", 32'(reg_write), 32'd0);

        // sub x3, x1, x2: alu_ctl[3] from inst[30].
        decode(32'h4020_81B3, 32'h8000_0028, 1'b0);
        check_ctl("sub", 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        check("sub.imm", imm, 32'd0);

        // srai x4, x4, 3: shift immediate carries inst[30] into alu_ctl[3].
        decode(32'h4032_5213, 32'h8000_002C, 1'b0);
        check_ctl("srai", 4'hD, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        check("srai.imm", imm, 32'h0000_0403);

        // OP with unsupported funct7, then an unlisted opcode.
        decode(32'h2020_81B3, 32'h8000_0030, 1'b0);
        check_ctl("badf7", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        decode(32'h0000_007B, 32'h8000_0034, 1'b0);
        check_ctl("badopc", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

        // ecall (SYSTEM) decodes as a legal no-op.
        decode(32'h0000_0073, 32'h8000_0038, 1'b0);
        check_ctl("ecall", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // phase_decode=0: new inputs must not disturb held outputs.
        decode(32'h0000_8067, 32'h8000_003C, 1'b0);
        inst       = 32'h0043_2283;
        curr_pc_fd = 32'h1234_0000;
        next_pc_fd = 32'h1234_0004;
        repeat (3) @(posedge clk);
        #1;
        check("hold.curr_pc", curr_pc_de, 32'h8000_003C);
        check("hold.jump", 32'(jump_type), 32'd2);
        check("hold.mem_read", 32'(mem_read), 32'd0);

        // Reset coincident with a decode strobe wins.
        inst         = 32'h0043_2283;
        phase_decode = 1'b1;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        phase_decode = 1'b0;
        check("mrst.curr_pc", curr_pc_de, 32'h8000_0000);
        check("mrst.next_pc", next_pc_de, 32'h8000_0004);
        check("mrst.valid", 32'(valid_de), 32'd0);
        check("mrst.jump", 32'(jump_type), 32'd0);
        check("mrst.mem_read", 32'(mem_read), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
